// File: rtl/axi_gpio_irq_if.sv
// AXI-lite slave bus bundle for the GPIO block.
// master: drives address/data/valid and response-ready signals.
// slave : drives ready signals, write response and read data.
interface axi_gpio_irq_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid
    );
endinterface

// File: rtl/axi_gpio_irq.sv
// AXI-lite GPIO slave with per-pin direction, atomic set/clear, byte-strobe
// writes, input synchroniser and edge interrupts (W1C status, level irq).
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : AXI-lite slave (axi_gpio_irq_if.slave), offset in addr[4:0]
//   gpio_in   : asynchronous pad inputs
//   gpio_out  : pad output values
//   gpio_oe   : pad output enables, 1 = drive
//   irq       : registered OR of the interrupt status register
module axi_gpio_irq #(
    parameter int unsigned GPIO_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    axi_gpio_irq_if.slave     bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    localparam int unsigned MASK_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned CNT_W       = $clog2(MASK_CYCLES + 1);

    localparam logic [4:0] OFF_IN      = 5'h00;
    localparam logic [4:0] OFF_OUT     = 5'h04;
    localparam logic [4:0] OFF_DIR     = 5'h08;
    localparam logic [4:0] OFF_RISE_EN = 5'h0C;
    localparam logic [4:0] OFF_FALL_EN = 5'h10;
    localparam logic [4:0] OFF_STATUS  = 5'h14;
    localparam logic [4:0] OFF_OUT_SET = 5'h18;
    localparam logic [4:0] OFF_OUT_CLR = 5'h1C;

    // register state
    logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [GPIO_W-1:0] out_d, dir_d, rise_en_d, fall_en_d, status_d;
    logic [GPIO_W-1:0] status_clr;

    // input path
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] sync_last;
    logic [GPIO_W-1:0] prev_q;
    logic [GPIO_W-1:0] edge_ev;
    logic [CNT_W-1:0]  mask_cnt_q;
    logic              edge_en;

    // bus side
    logic              bvalid_q, rvalid_q, irq_q;
    logic [31:0]       rdata_q;
    logic              wr_acc, rd_acc;
    logic [4:0]        waddr;
    logic [31:0]       wmask32;
    logic [GPIO_W-1:0] wmask, wbits;
    logic [31:0]       rd_data_c;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{bus.s_awaddr[31:5], bus.s_araddr[31:5]};

    assign bus.s_awready = ~bvalid_q;
    assign bus.s_wready  = ~bvalid_q;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_arready = ~rvalid_q;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rdata   = rdata_q;

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

    // Address and data must both be present; only one write in flight.
    assign wr_acc = bus.s_awvalid & bus.s_wvalid & ~bvalid_q;
    assign rd_acc = bus.s_arvalid & ~rvalid_q;
    assign waddr  = bus.s_awaddr[4:0];

    // Expand byte strobes to a bit mask, then keep only implemented pins.
    always_comb begin
        wmask32 = '0;
        for (int n = 0; n < 4; n++) begin
            wmask32[8*n +: 8] = {8{bus.s_wstrb[n]}};
        end
    end

    assign wmask = GPIO_W'(wmask32);
    assign wbits = GPIO_W'(bus.s_wdata & wmask32);

    // Synchroniser chain and previous-value flop for edge detection.
    assign sync_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_last;
        end
    end

    // Hold off edge detection until the chain has flushed its reset zeros,
    // so a pin already high at reset release does not look like a rise.
    assign edge_en = (mask_cnt_q == CNT_W'(MASK_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_cnt_q <= '0;
        end else if (!edge_en) begin
            mask_cnt_q <= mask_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        edge_ev = '0;
        if (edge_en) begin
            edge_ev = (sync_last & ~prev_q & rise_en_q)
                    | (~sync_last & prev_q & fall_en_q);
        end
    end

    // Register write decode; a new edge beats a same-cycle W1C.
    always_comb begin
        out_d      = out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (wr_acc) begin
            case (waddr)
                OFF_OUT:     out_d      = (out_q & ~wmask) | wbits;
                OFF_DIR:     dir_d      = (dir_q & ~wmask) | wbits;
                OFF_RISE_EN: rise_en_d  = (rise_en_q & ~wmask) | wbits;
                OFF_FALL_EN: fall_en_d  = (fall_en_q & ~wmask) | wbits;
                OFF_STATUS:  status_clr = wbits;
                OFF_OUT_SET: out_d      = out_q | wbits;
                OFF_OUT_CLR: out_d      = out_q & ~wbits;
                default:     ;
            endcase
        end
        status_d = (status_q & ~status_clr) | edge_ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= |status_q;
        end
    end

    // Write response channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0;
        end else if (wr_acc) begin
            bvalid_q <= 1'b1;
        end else if (bus.s_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data mux; write-only and unmapped offsets return zero.
    always_comb begin
        rd_data_c = '0;
        case (bus.s_araddr[4:0])
            OFF_IN:      rd_data_c = 32'(sync_last);
            OFF_OUT:     rd_data_c = 32'(out_q);
            OFF_DIR:     rd_data_c = 32'(dir_q);
            OFF_RISE_EN: rd_data_c = 32'(rise_en_q);
            OFF_FALL_EN: rd_data_c = 32'(fall_en_q);
            OFF_STATUS:  rd_data_c = 32'(status_q);
            default:     ;
        endcase
    end

    // Read channel; rdata only changes on a new accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (rd_acc) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_c;
        end else if (bus.s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: doc/axi_gpio_irq.md
Name: axi_gpio_irq

Overview:
Parametrised, second-generation AXI-lite GPIO slave for the SoC peripheral bus.
- Per-pin direction control.
- Atomic set/clear of outputs.
- Byte-strobe writes.
- Input synchroniser.
- Per-pin rising/falling edge interrupts with write-1-to-clear status, and one level interrupt line to the core.

Parameters:
GPIO_W, 16, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser flops (2..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_awaddr  in  32  write address (offset in [4:0])
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte write enables
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  32  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
gpio_in  in  GPIO_W  pad inputs, asynchronous
gpio_out  out  GPIO_W  pad output values
gpio_oe  out  GPIO_W  pad output enables, 1=drive
irq  out  1  OR of (IRQ_STATUS), registered

Behaviour:
- Register map (offset [4:0]):
  - 0x00 IN (RO): synchronised input.
  - 0x04 OUT (RW).
  - 0x08 DIR (RW): 1=output.
  - 0x0C RISE_EN (RW).
  - 0x10 FALL_EN (RW).
  - 0x14 STATUS (RW1C).
  - 0x18 OUT_SET (WO): OUT |= data.
  - 0x1C OUT_CLR (WO): OUT &= ~data.
  - WO offsets read 0.
- Unmapped offsets: writes ignored, reads 0, response still given. Bits above GPIO_W read 0, write ignored.
- Reset values: all registers 0; sync/prev flops 0; s_bvalid=0, s_rvalid=0, s_rdata=0, irq=0; gpio_out=0, gpio_oe=0.
- Write handshake:
  - s_awready = s_wready = !s_bvalid.
  - Accepted on the edge where s_awvalid & s_wvalid & !s_bvalid. Address-only or data-only presentation is not accepted.
  - On acceptance: register updated and s_bvalid=1 on the same edge; the new value is visible on gpio_out/gpio_oe the following cycle.
  - s_bvalid cleared on the edge with s_bready=1.
  - At most one write outstanding.
- s_wstrb: byte lane n updates bits [8n+7:8n] only. Applies to every writable register including SET/CLR/STATUS; lanes with strobe 0 have no effect.
- Read handshake:
  - s_arready = !s_rvalid.
  - On acceptance, s_rdata and s_rvalid=1 are loaded on the same edge.
  - s_rdata is held stable until the edge with s_rready=1, which clears s_rvalid. s_rdata keeps its last value afterwards.
  - Reads and writes are independent and may complete in the same cycle.
- Synchroniser: SYNC_STAGES flop chain per pin; IN returns the last stage.
- Edge detect:
  - prev <= sync each cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - STATUS[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). Detection is independent of DIR, so output pins loop back via the pad.
- Latency: gpio_in change -> STATUS bit set after SYNC_STAGES+1 edges; irq high one edge later.
- Reset masking:
  - A counter suppresses edge detection for SYNC_STAGES+1 cycles after reset release.
  - A pin tied high at reset therefore produces no spurious rise.
- Simultaneous events:
  - W1C and a new edge on the same STATUS bit in one cycle: set wins, bit stays 1.
  - Disabling RISE_EN/FALL_EN does not clear STATUS.
- Reset asserted mid-transaction: all state returns to reset values immediately. Outstanding responses are dropped; the master must not expect them.

Test Plan:
- Reset with gpio_in=16'hFFFF held -> gpio_out=0, gpio_oe=0, irq=0; read 0x14 returns 0 after SYNC_STAGES+2 cycles; read 0x00 returns 0x0000FFFF.
- Write 0x04=0x1234, then 0x18=0x0F00, then 0x1C=0x0004 -> read 0x04 returns 0x00001F30; gpio_out=16'h1F30.
- Write 0x08=0xABCD with s_wstrb=4'b0001 -> DIR=0x00CD; gpio_oe=16'h00CD.
- RISE_EN=0x0001, FALL_EN=0x0002; toggle gpio_in[0] 0->1 and gpio_in[1] 1->0 -> STATUS=0x3 after 3 edges, irq=1 next edge. Write 0x14=0x1 -> STATUS=0x2, irq stays 1. Write 0x14=0x2 -> irq=0.
- W1C of bit0 in the same cycle as a new rise on pin0 -> STATUS[0] remains 1.
- Hold s_bready=0 for 5 cycles after a write -> s_bvalid stays 1, s_awready=0; a second write is not accepted until s_bready pulses. Repeat for the read channel with s_rdata stable throughout.
